// File: rtl/qmults_radix_if.sv
// Request/result bundle for the radix-K signed-magnitude Q-format multiplier.
// The master side issues operands and consumes results; the slave side is the multiplier.
interface qmults_radix_if #(
    parameter int N = 32
);
    logic [N-1:0] i_multiplicand;
    logic [N-1:0] i_multiplier;
    logic         i_round;
    logic         i_start;
    logic         o_ready;
    logic [N-1:0] o_result_out;
    logic         o_valid;
    logic         i_ready;
    logic         o_overflow;

    modport slave (
        input  i_multiplicand,
        input  i_multiplier,
        input  i_round,
        input  i_start,
        input  i_ready,
        output o_ready,
        output o_result_out,
        output o_valid,
        output o_overflow
    );

    modport master (
        output i_multiplicand,
        output i_multiplier,
        output i_round,
        output i_start,
        output i_ready,
        input  o_ready,
        input  o_result_out,
        input  o_valid,
        input  o_overflow
    );
endinterface

// File: rtl/qmults_radix.sv
// Sequential signed-magnitude Q(N-1-Q).Q multiplier retiring K multiplier bits per cycle,
// with optional round-half-up, overflow detection and saturation.
module qmults_radix #(
    parameter int N   = 32,
    parameter int Q   = 15,
    parameter int K   = 1,
    parameter int SAT = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    qmults_radix_if.slave bus
);
    localparam int MW   = N - 1;
    localparam int PW   = 2 * N - 2;
    localparam int RW   = PW - Q + 1;
    localparam int ITER = (N - 1) / K;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    typedef enum logic [1:0] {IDLE, MUL, FINAL, DONE} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [PW-1:0]   a_shift_reg;
    logic [MW-1:0]   b_shift_reg;
    logic [PW-1:0]   acc_reg;
    logic [CW-1:0]   count_reg;
    logic            sign_reg;
    logic            round_reg;
    logic [N-1:0]    result_reg;
    logic            overflow_reg;
    logic            valid_reg;

    logic            accept;
    logic            last_iter;
    logic [PW-1:0]   pp [K];
    logic [PW-1:0]   partial;
    logic [RW-1:0]   rounded;
    logic            ovf;
    logic [MW-1:0]   mag;
    logic [N-1:0]    result_next;
    logic            unused_bits;

    assign accept    = bus.i_start && (state_reg == IDLE);
    assign last_iter = (count_reg == CW'(ITER - 1));

    // One shifted copy of |A| per multiplier bit in the current digit.
    genvar gi;
    generate
        for (gi = 0; gi < K; gi++) begin : g_pp
            assign pp[gi] = b_shift_reg[gi] ? (a_shift_reg << gi) : '0;
        end
    endgenerate

    always_comb begin
        partial = '0;
        for (int j = 0; j < K; j++) begin
            partial = partial + pp[j];
        end
    end

    // Keep one bit above the slice so a rounding carry still registers as overflow.
    always_comb begin
        rounded     = {1'b0, acc_reg[PW-1:Q]} + RW'(round_reg & acc_reg[Q-1]);
        ovf         = |rounded[RW-1:N-1];
        mag         = (ovf && (SAT != 0)) ? '1 : rounded[N-2:0];
        result_next = {sign_reg & (mag != '0), mag};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MUL;
            MUL:     if (last_iter) state_next = FINAL;
            FINAL:   state_next = DONE;
            DONE:    if (bus.i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_shift_reg  <= '0;
            b_shift_reg  <= '0;
            acc_reg      <= '0;
            count_reg    <= '0;
            sign_reg     <= 1'b0;
            round_reg    <= 1'b0;
            result_reg   <= '0;
            overflow_reg <= 1'b0;
            valid_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_shift_reg <= PW'(bus.i_multiplicand[N-2:0]);
                        b_shift_reg <= bus.i_multiplier[N-2:0];
                        sign_reg    <= bus.i_multiplicand[N-1] ^ bus.i_multiplier[N-1];
                        round_reg   <= bus.i_round;
                        acc_reg     <= '0;
                        count_reg   <= '0;
                    end
                end
                MUL: begin
                    acc_reg     <= acc_reg + partial;
                    a_shift_reg <= a_shift_reg << K;
                    b_shift_reg <= b_shift_reg >> K;
                    count_reg   <= count_reg + 1'b1;
                end
                FINAL: begin
                    result_reg   <= result_next;
                    overflow_reg <= ovf;
                    valid_reg    <= 1'b1;
                end
                DONE: begin
                    if (bus.i_ready) valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign unused_bits = ^acc_reg;

    assign bus.o_ready      = (state_reg == IDLE);
    assign bus.o_valid      = valid_reg;
    assign bus.o_result_out = result_reg;
    assign bus.o_overflow   = overflow_reg;
endmodule

// File: tb/tb_qmults_radix.sv
// Directed bench for qmults_radix: three instances (K=1 saturating, K=31 saturating,
// K=31 wrapping) sharing one clock and reset, checked against hand-computed products.
module tb_qmults_radix;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    qmults_radix_if #(.N(32)) bus_k1 ();
    qmults_radix_if #(.N(32)) bus_k31 ();
    qmults_radix_if #(.N(32)) bus_wrap ();

    qmults_radix #(.N(32), .Q(15), .K(1),  .SAT(1)) dut_k1   (.i_clk(clk), .i_rst(rst), .bus(bus_k1));
    qmults_radix #(.N(32), .Q(15), .K(31), .SAT(1)) dut_k31  (.i_clk(clk), .i_rst(rst), .bus(bus_k31));
    qmults_radix #(.N(32), .Q(15), .K(31), .SAT(0)) dut_wrap (.i_clk(clk), .i_rst(rst), .bus(bus_wrap));

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        rnd;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic rnd, input logic start, input logic rdy);
        case (sel)
            0: begin
                bus_k1.i_multiplicand = a; bus_k1.i_multiplier = b; bus_k1.i_round = rnd;
                bus_k1.i_start = start; bus_k1.i_ready = rdy;
            end
            1: begin
                bus_k31.i_multiplicand = a; bus_k31.i_multiplier = b; bus_k31.i_round = rnd;
                bus_k31.i_start = start; bus_k31.i_ready = rdy;
            end
            default: begin
                bus_wrap.i_multiplicand = a; bus_wrap.i_multiplier = b; bus_wrap.i_round = rnd;
                bus_wrap.i_start = start; bus_wrap.i_ready = rdy;
            end
        endcase
    endtask

    task automatic get_out(input int sel, output logic [31:0] res, output logic ovf,
                           output logic vld, output logic rdy);
        case (sel)
            0:       begin res = bus_k1.o_result_out;   ovf = bus_k1.o_overflow;   vld = bus_k1.o_valid;   rdy = bus_k1.o_ready;   end
            1:       begin res = bus_k31.o_result_out;  ovf = bus_k31.o_overflow;  vld = bus_k31.o_valid;  rdy = bus_k31.o_ready;  end
            default: begin res = bus_wrap.o_result_out; ovf = bus_wrap.o_overflow; vld = bus_wrap.o_valid; rdy = bus_wrap.o_ready; end
        endcase
    endtask

    task automatic check_idle(input int sel, input string tag);
        logic [31:0] res;
        logic        ovf, vld, rdy;
        get_out(sel, res, ovf, vld, rdy);
        chk({tag, "_ready"}, 64'(rdy), 64'd1);
        chk({tag, "_valid"}, 64'(vld), 64'd0);
        chk({tag, "_result"}, 64'(res), 64'd0);
        chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    endtask

    // Accept happens at the next edge; returns with inputs released, #1 after that edge.
    task automatic issue(input int sel, input logic [31:0] a, input logic [31:0] b, input logic rnd);
        set_in(sel, a, b, rnd, 1'b1, 1'b0);
        @(posedge clk); #1;
        set_in(sel, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_valid(input int sel, output int cyc);
        logic [31:0] res;
        logic        ovf, vld, rdy;
        cyc = 0;
        get_out(sel, res, ovf, vld, rdy);
        while (!vld && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            get_out(sel, res, ovf, vld, rdy);
        end
    endtask

    task automatic run_op(input vec_t v, input string tag);
        logic [31:0] res;
        logic        ovf, vld, rdy;
        int          cyc;
        int          exp_lat;
        exp_lat = (v.sel == 0) ? 32 : 2;
        issue(v.sel, v.a, v.b, v.rnd);
        get_out(v.sel, res, ovf, vld, rdy);
        chk({tag, "_busy"}, 64'(rdy), 64'd0);
        wait_valid(v.sel, cyc);
        get_out(v.sel, res, ovf, vld, rdy);
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_res"}, 64'(res), 64'(v.res));
        chk({tag, "_ovf"}, 64'(ovf), 64'(v.ovf));
        $display("op %s sel=%0d a=%h b=%h rnd=%b -> res=%h ovf=%b lat=%0d", tag, v.sel, v.a, v.b, v.rnd, res, ovf, cyc);
        set_in(v.sel, '0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(v.sel, '0, '0, 1'b0, 1'b0, 1'b0);
        get_out(v.sel, res, ovf, vld, rdy);
        chk({tag, "_drop_valid"}, 64'(vld), 64'd0);
        chk({tag, "_idle"}, 64'(rdy), 64'd1);
    endtask

    initial begin
        logic [31:0] res;
        logic        ovf, vld, rdy;
        int          cyc;

        vecs = '{
            '{0, 32'h0000C000, 32'h00010000, 1'b0, 32'h00018000, 1'b0},
            '{0, 32'h80004000, 32'h80008000, 1'b0, 32'h00004000, 1'b0},
            '{0, 32'h00000001, 32'h00004000, 1'b1, 32'h00000001, 1'b0},
            '{1, 32'h8000C000, 32'h00010000, 1'b0, 32'h80018000, 1'b0},
            '{1, 32'h7FFFFFFF, 32'h00010000, 1'b0, 32'h7FFFFFFF, 1'b1},
            '{1, 32'h00000001, 32'h00004000, 1'b0, 32'h00000000, 1'b0},
            '{1, 32'h00000001, 32'h00004000, 1'b1, 32'h00000001, 1'b0},
            '{1, 32'h80000001, 32'h00004000, 1'b0, 32'h00000000, 1'b0},
            '{1, 32'h80000001, 32'h00004000, 1'b1, 32'h80000001, 1'b0},
            '{1, 32'h80000000, 32'h00010000, 1'b0, 32'h00000000, 1'b0},
            '{1, 32'h0000FFFF, 32'h40004000, 1'b1, 32'h7FFFFFFF, 1'b1},
            '{1, 32'h0000FFFF, 32'h40004000, 1'b0, 32'h7FFFFFFF, 1'b0},
            '{2, 32'h7FFFFFFF, 32'h00010000, 1'b0, 32'h7FFFFFFE, 1'b1},
            '{2, 32'h0000FFFF, 32'h40004000, 1'b1, 32'h00000000, 1'b1},
            '{2, 32'h8000C000, 32'h00010000, 1'b0, 32'h80018000, 1'b0}
        };

        for (int s = 0; s < 3; s++) set_in(s, '0, '0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_idle(0, "rst_k1");
        check_idle(1, "rst_k31");
        check_idle(2, "rst_wrap");

        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i], $sformatf("v%0d", i));
        end

        // Back-pressure: result held, request side closed, a stray start is dropped.
        issue(1, 32'h0000C000, 32'h00010000, 1'b0);
        wait_valid(1, cyc);
        chk("bp_lat", 64'(cyc), 64'd2);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) set_in(1, 32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b1, 1'b0);
            else        set_in(1, '0, '0, 1'b0, 1'b0, 1'b0);
            @(posedge clk); #1;
            get_out(1, res, ovf, vld, rdy);
            chk($sformatf("bp_res%0d", c), 64'(res), 64'h00018000);
            chk($sformatf("bp_ovf%0d", c), 64'(ovf), 64'd0);
            chk($sformatf("bp_vld%0d", c), 64'(vld), 64'd1);
            chk($sformatf("bp_rdy%0d", c), 64'(rdy), 64'd0);
        end
        $display("op backpressure sel=1 held result=%h for 10 cycles", res);
        set_in(1, '0, '0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        set_in(1, '0, '0, 1'b0, 1'b0, 1'b0);
        get_out(1, res, ovf, vld, rdy);
        chk("bp_release_vld", 64'(vld), 64'd0);
        chk("bp_release_rdy", 64'(rdy), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        get_out(1, res, ovf, vld, rdy);
        chk("bp_no_queue_vld", 64'(vld), 64'd0);
        chk("bp_no_queue_rdy", 64'(rdy), 64'd1);

        // Reset in the middle of MUL on the K=1 instance (it still holds a nonzero result).
        issue(0, 32'h00018000, 32'h80002000, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_idle(0, "midrst_k1");
        $display("op midreset sel=0 outputs cleared");
        run_op('{0, 32'h00018000, 32'h80002000, 1'b0, 32'h80006000, 1'b0}, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
